// File: rtl/risk_alert_sequencer.sv
// risk_alert_sequencer
//
// Classifies each qualified 16-bit risk score as NORMAL, CAUTION or WARNING,
// filters level changes through persistence (escalate) and clear
// (de-escalate) counters, and latches master-warning / master-caution
// annunciators until the crew acknowledges them.
//
// Ports:
//   clk_i            system clock (single domain)
//   rst_i            synchronous, active-high reset
//   sample_en_i      qualifies risk_score_i this cycle
//   risk_score_i     registered score from the flight data processor
//   ack_i            crew acknowledge, clears latched annunciators
//   alert_level_o    0 = NORMAL, 1 = CAUTION, 2 = WARNING
//   master_warn_o    latched warning annunciator
//   master_caution_o latched caution annunciator
//   level_change_o   one-cycle pulse the cycle after any level transition
//   alert_cause_o    risk_score_i[15:8] of the sample that last escalated
//   warn_events_o    saturating count of entries to WARNING
module risk_alert_sequencer #(
  parameter int unsigned PERSIST_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_en_i,
  input  logic [15:0] risk_score_i,
  input  logic        ack_i,
  output logic [1:0]  alert_level_o,
  output logic        master_warn_o,
  output logic        master_caution_o,
  output logic        level_change_o,
  output logic [7:0]  alert_cause_o,
  output logic [7:0]  warn_events_o
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    CAUTION = 2'd1,
    WARNING = 2'd2
  } state_e;

  localparam logic [8:0] PersistThresh = 9'(PERSIST_CYCLES);
  localparam logic [7:0] ClearThresh   = 8'(CLEAR_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] up_cnt_q, up_cnt_d;
  logic [7:0] dn_cnt_q, dn_cnt_d;
  logic       warn_q, warn_d;
  logic       caution_q, caution_d;
  logic       change_q;
  logic [7:0] cause_q, cause_d;
  logic [7:0] events_q, events_d;

  state_e     target;
  logic [8:0] up_inc;
  logic [7:0] dn_sat;

  // Low byte never influences classification or the logged cause.
  logic       unused_score_bits;
  assign unused_score_bits = ^risk_score_i[7:0];

  // Warning bits take priority over caution bits; bits 12 and 8:0 are ignored.
  always_comb begin
    target = NORMAL;
    if (|risk_score_i[15:13]) begin
      target = WARNING;
    end else if (|risk_score_i[11:9]) begin
      target = CAUTION;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= NORMAL;
      up_cnt_q  <= 8'd0;
      dn_cnt_q  <= 8'd0;
      warn_q    <= 1'b0;
      caution_q <= 1'b0;
      change_q  <= 1'b0;
      cause_q   <= 8'd0;
      events_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      up_cnt_q  <= up_cnt_d;
      dn_cnt_q  <= dn_cnt_d;
      warn_q    <= warn_d;
      caution_q <= caution_d;
      change_q  <= (state_d != state_q);
      cause_q   <= cause_d;
      events_q  <= events_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    up_cnt_d  = up_cnt_q;
    dn_cnt_d  = dn_cnt_q;
    warn_d    = warn_q;
    caution_d = caution_q;
    cause_d   = cause_q;
    events_d  = events_q;

    // 9-bit so a PERSIST of 255 cannot wrap before matching.
    up_inc = {1'b0, up_cnt_q} + 9'd1;
    dn_sat = (dn_cnt_q >= ClearThresh) ? ClearThresh : dn_cnt_q + 8'd1;

    // Ack clears first so that a simultaneous set below overrides it.
    if (ack_i) begin
      warn_d    = 1'b0;
      caution_d = 1'b0;
    end

    if (sample_en_i) begin
      if (target > state_q) begin
        dn_cnt_d = 8'd0;
        up_cnt_d = up_inc[7:0];
        // Jump goes to this sample's target even if earlier samples differed.
        if (up_inc == PersistThresh) begin
          state_d  = target;
          up_cnt_d = 8'd0;
          cause_d  = risk_score_i[15:8];
          if (target == WARNING) begin
            warn_d = 1'b1;
            if (events_q != 8'hFF) begin
              events_d = events_q + 8'd1;
            end
          end else if (state_q == NORMAL) begin
            caution_d = 1'b1;
          end
        end
      end else if (target < state_q) begin
        up_cnt_d = 8'd0;
        dn_cnt_d = dn_sat;
        // An unacknowledged master warning pins the level; dn_cnt parks at
        // the threshold so the drop happens on the first sample after ack.
        if (!(state_q == WARNING && warn_q) && dn_sat == ClearThresh) begin
          state_d  = target;
          up_cnt_d = 8'd0;
          dn_cnt_d = 8'd0;
        end
      end else begin
        up_cnt_d = 8'd0;
        dn_cnt_d = 8'd0;
      end
    end
  end

  assign alert_level_o    = state_q;
  assign master_warn_o    = warn_q;
  assign master_caution_o = caution_q;
  assign level_change_o   = change_q;
  assign alert_cause_o    = cause_q;
  assign warn_events_o    = events_q;

endmodule

// File: doc/risk_alert_sequencer.md
# risk_alert_sequencer

Downstream consumer of the flight data processor's 16-bit `risk_score` register. It classifies each sampled score as none, caution or warning. Level changes are filtered through persistence and clear counters, and the block latches master-warning and master-caution annunciators that the crew must acknowledge. Outputs drive the cockpit annunciator interface and the event logger.

## Interface
- `PERSIST_CYCLES`, 4: consecutive qualifying samples needed to escalate (legal range 1..255).
- `CLEAR_CYCLES`, 8: consecutive lower samples needed to de-escalate (legal range 1..255).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sample_en`  in  1  qualifies `risk_score` this cycle.
- `risk_score`  in  16  registered score from the flight data processor.
- `ack`  in  1  crew acknowledge pulse; level-sensitive per cycle.
- `alert_level`  out  2  0 = NORMAL, 1 = CAUTION, 2 = WARNING; 3 is never driven.
- `master_warn`  out  1  latched warning annunciator.
- `master_caution`  out  1  latched caution annunciator.
- `level_change`  out  1  one-cycle pulse when `alert_level` changes.
- `alert_cause`  out  8  `risk_score[15:8]` of the sample that caused the last escalation.
- `warn_events`  out  8  saturating count of entries to WARNING.

## Operation
**Sample classification** (only on `sample_en` = 1):
- `target` = 2 if any of `risk_score[15:13]` is set.
- else `target` = 1 if any of `risk_score[11:9]` is set.
- else `target` = 0.
- All other bits are ignored.

**State machine**
- States NORMAL, CAUTION, WARNING; the state is output directly as `alert_level`.
- Counters `up_cnt` and `dn_cnt`, 8 bits each.
- Counters change only on `sample_en` cycles and hold otherwise.

**On a `sample_en` cycle:**
- `target` > level:
  - `dn_cnt` := 0; `up_cnt` increments.
  - When the increment reaches `PERSIST_CYCLES`, the state jumps directly to `target`; NORMAL→WARNING is legal.
  - The escalation also clears both counters and loads `alert_cause`.
  - A sample with a different higher `target` does not reset `up_cnt`; the jump goes to the current sample's `target`.
- `target` < level:
  - `up_cnt` := 0; `dn_cnt` increments, saturating at `CLEAR_CYCLES`.
  - When `dn_cnt` reaches `CLEAR_CYCLES`, the state drops to `target` and both counters clear.
  - Exception: in WARNING with `master_warn` = 1, the state does not drop and `dn_cnt` holds at `CLEAR_CYCLES`.
  - The drop then occurs on the first `sample_en` cycle with `target` < level and `master_warn` = 0, as sampled that cycle.
- `target` = level: both counters := 0.

**Annunciators**
- Entering WARNING sets `master_warn` and increments `warn_events` (saturating at 255).
- Entering CAUTION from NORMAL sets `master_caution`.
- Dropping from WARNING to CAUTION does not set `master_caution`.
- `ack` = 1 clears both `master_warn` and `master_caution`.
- If `ack` and a set event occur in the same cycle, the set wins.
- `ack` while nothing is latched has no effect.
- `level_change` = 1 for exactly the cycle after any state transition.

**Reset**
- On `rst` = 1 at a clock edge, all outputs and counters go to 0 and the state goes to NORMAL, regardless of any in-progress counts.
- `rst` overrides `sample_en` and `ack`.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Escalation latency: the level changes at the clock edge that samples the `PERSIST_CYCLES`-th consecutive qualifying `sample_en`.
- The new level, latched annunciator, `alert_cause`, `warn_events` and `level_change` are all visible the following cycle.
- De-escalation latency follows the same rule with `CLEAR_CYCLES`.
- `sample_en` gaps do not break a consecutive run; only a disqualifying sample does.
- `ack` takes effect at the next edge; `master_warn` is low one cycle after `ack`.

## Test plan
- **Reset:** hold `rst` 2 cycles while `sample_en` = 1 and `risk_score` = 16'h8000 → all outputs 0; `alert_level` = 0 on the first cycle after `rst` deasserts.
- **Escalate to WARNING:** 4 samples of 16'h8800 → `alert_level` = 2, `master_warn` = 1, `alert_cause` = 8'h88, `warn_events` = 1, one `level_change` pulse.
  - With 3 samples of 16'h8800 followed by 16'h0000 → no change.
- **De-escalation blocked until ack:**
  - From WARNING, send 10 samples of 16'h0000 → level stays 2.
  - Pulse `ack`, then send 1 sample of 16'h0000 → `alert_level` = 0.
- **CAUTION path:**
  - 4 samples of 16'h0200 → level 1, `master_caution` = 1.
  - 2 samples of 16'h0000 then 16'h0200 → `dn_cnt` resets, level stays 1.
- **Ack/set collision:** assert `ack` in the same cycle as the 4th 16'h8000 sample → `master_warn` = 1 afterwards.
- **Saturation:** 260 WARNING entry/exit cycles, each with an ack → `warn_events` = 255.
  - Idle cycles interleaved with `sample_en` = 0 inside a run → run still completes after 4 qualifying samples.
